// File: rtl/spi_xfer_ctrl.sv
// SPI master transfer sequencer: chip select, divided SCK with CPOL/CPHA,
// MSB-first MOSI shifting, MISO capture and a one-cycle done pulse.
module spi_xfer_ctrl #(
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [DATA_W-1:0] tx_data,
   input  logic [1:0]        prescaler,
   input  logic              cpol,
   input  logic              cpha,
   input  logic              miso,
   output logic              sck,
   output logic              mosi,
   output logic              ss_n,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] rx_data
);

   localparam int unsigned EDGES = 2 * DATA_W;
   localparam int unsigned EW    = $clog2(EDGES + 1);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      XFER,
      HOLD,
      DONE
   } state_t;

   state_t            state;
   logic [1:0]        half_cnt;
   logic [1:0]        half_max;
   logic [EW-1:0]     edge_cnt;
   logic [DATA_W-1:0] tx_shift;
   logic [DATA_W-1:0] rx_shift;
   logic              pha_q;

   logic half_end_c;
   logic sample_c;
   logic drive_c;

   // edge_cnt holds the number of SCK edges produced so far; edge k is leading when k is odd
   assign half_end_c = (half_cnt == half_max);
   assign sample_c   = (state == XFER) && (half_cnt == 2'd0) && (edge_cnt[0] != pha_q);
   assign drive_c    = pha_q ? ~edge_cnt[0]
                             : (edge_cnt[0] && (edge_cnt != EW'(EDGES - 1)));

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         sck      <= 1'b0;
         mosi     <= 1'b0;
         ss_n     <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
         rx_data  <= '0;
         half_cnt <= 2'd0;
         half_max <= 2'd0;
         edge_cnt <= '0;
         tx_shift <= '0;
         rx_shift <= '0;
         pha_q    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               sck <= cpol;
               if (start) begin
                  state    <= SETUP;
                  ss_n     <= 1'b0;
                  busy     <= 1'b1;
                  half_cnt <= 2'd0;
                  half_max <= prescaler;
                  edge_cnt <= '0;
                  pha_q    <= cpha;
                  // cpha=0 presents the MSB before the first (sampling) edge
                  if (!cpha) begin
                     mosi     <= tx_data[DATA_W-1];
                     tx_shift <= {tx_data[DATA_W-2:0], 1'b0};
                  end else begin
                     tx_shift <= tx_data;
                  end
               end else begin
                  state <= IDLE;
                  ss_n  <= 1'b1;
                  busy  <= 1'b0;
               end
            end

            SETUP, XFER, HOLD: begin
               if (abort) begin
                  state    <= IDLE;
                  ss_n     <= 1'b1;
                  busy     <= 1'b0;
                  sck      <= cpol;
                  half_cnt <= 2'd0;
               end else begin
                  if (sample_c) begin
                     rx_shift <= {rx_shift[DATA_W-2:0], miso};
                  end
                  half_cnt <= half_end_c ? 2'd0 : half_cnt + 2'd1;
                  if (half_end_c) begin
                     if (state == HOLD) begin
                        state   <= DONE;
                        ss_n    <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        rx_data <= rx_shift;
                     end else if (edge_cnt == EW'(EDGES)) begin
                        state <= HOLD;
                     end else begin
                        state    <= XFER;
                        sck      <= ~sck;
                        edge_cnt <= edge_cnt + EW'(1);
                        if (drive_c) begin
                           mosi     <= tx_shift[DATA_W-1];
                           tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                        end
                     end
                  end
               end
            end

            default: begin
               state <= IDLE;
               ss_n  <= 1'b1;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Self-checking bench for spi_xfer_ctrl: a negedge bus monitor plus slave model,
// with expected results computed from frame-level SPI rules.
module tb_spi_xfer_ctrl;

   localparam int D = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         abort;
   logic [D-1:0] tx_data;
   logic [1:0]   prescaler;
   logic         cpol;
   logic         cpha;
   logic         miso;
   logic         sck;
   logic         mosi;
   logic         ss_n;
   logic         busy;
   logic         done;
   logic [D-1:0] rx_data;

   int n_vec = 0;
   int n_err = 0;

   // frame context used by the monitor and slave model
   logic         fr_cpol = 1'b0;
   logic         fr_cpha = 1'b0;
   int           fr_h = 1;
   int           miso_mode = 0;   // 0 loopback, 1 inverted loopback, 2 slave byte
   logic [D-1:0] slave_byte = '0;
   logic         miso_slv = 1'b0;

   // monitor results
   int           m_low = 0;
   int           m_edges = 0;
   int           m_rises = 0;
   int           m_tim_err = 0;
   int           m_idle_err = 0;
   int           m_done = 0;
   int           s_idx = 0;
   logic [D-1:0] m_mosi = '0;
   logic         prev_ss = 1'b1;
   logic         prev_sck = 1'b0;

   // per-frame observations
   logic         obs_timeout;
   logic [D-1:0] obs_rx;
   logic         obs_busy;
   logic [D-1:0] last_exp_rx = '0;

   always #5 clk = ~clk;

   assign miso = (miso_mode == 0) ? mosi : (miso_mode == 1) ? ~mosi : miso_slv;

   spi_xfer_ctrl #(.DATA_W(D)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .abort     (abort),
      .tx_data   (tx_data),
      .prescaler (prescaler),
      .cpol      (cpol),
      .cpha      (cpha),
      .miso      (miso),
      .sck       (sck),
      .mosi      (mosi),
      .ss_n      (ss_n),
      .busy      (busy),
      .done      (done),
      .rx_data   (rx_data)
   );

   // Bus monitor and slave: edge k must appear H*k cycles after ss_n falls
   always @(negedge clk) begin
      logic lead;
      if (!ss_n && prev_ss) begin
         m_low      = 0;
         m_edges    = 0;
         m_rises    = 0;
         m_tim_err  = 0;
         m_idle_err = (sck !== fr_cpol) ? 1 : 0;
         m_mosi     = '0;
         m_done     = 0;
         s_idx      = 0;
         prev_sck   = sck;
         if (!fr_cpha) miso_slv = slave_byte[D-1];
      end
      if (!ss_n) begin
         m_low++;
         if (sck !== prev_sck) begin
            m_edges++;
            if (sck) m_rises++;
            if (m_low != fr_h * m_edges + 1) m_tim_err++;
            lead = ((m_edges % 2) == 1);
            if (lead != fr_cpha) m_mosi = {m_mosi[D-2:0], mosi};
            if (fr_cpha && lead) begin
               if (s_idx < D) miso_slv = slave_byte[D-1-s_idx];
               s_idx++;
            end else if (!fr_cpha && !lead && m_edges < 2 * D) begin
               s_idx++;
               if (s_idx < D) miso_slv = slave_byte[D-1-s_idx];
            end
         end
      end
      if (done === 1'b1) m_done++;
      prev_ss  = ss_n;
      prev_sck = sck;
   end

   function automatic logic [D-1:0] model_rx(input logic [D-1:0] tx, input int mode,
                                             input logic [D-1:0] slv);
      case (mode)
         0:       return tx;
         1:       return ~tx;
         default: return slv;
      endcase
   endfunction

   function automatic int model_low(input logic [1:0] ps);
      return (2 * D + 2) * (int'(ps) + 1);
   endfunction

   task automatic start_frame(input logic [D-1:0] tx, input logic pol, input logic pha,
                              input logic [1:0] ps, input int mode, input logic [D-1:0] slv);
      fr_cpol    = pol;
      fr_cpha    = pha;
      fr_h       = int'(ps) + 1;
      miso_mode  = mode;
      slave_byte = slv;
      tx_data    = tx;
      cpol       = pol;
      cpha       = pha;
      prescaler  = ps;
      start      = 1'b1;
      @(posedge clk); #1;
      start      = 1'b0;
   endtask

   task automatic wait_done();
      obs_timeout = 1'b1;
      for (int i = 0; i < 300 && obs_timeout; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            obs_timeout = 1'b0;
            obs_rx      = rx_data;
            obs_busy    = busy;
         end
      end
      @(posedge clk); #1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; abort = 1'b0; tx_data = '0;
      prescaler = 2'd0; cpol = 1'b0; cpha = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if ({sck, mosi, ss_n, busy, done, rx_data} !== {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
         n_err++;
         $display("FAIL reset_outputs got sck=%b mosi=%b ss_n=%b busy=%b done=%b rx=%h want 0 0 1 0 0 00",
                  sck, mosi, ss_n, busy, done, rx_data);
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_loopback();
      start_frame(8'hA5, 1'b0, 1'b0, 2'd0, 0, 8'h00);
      wait_done();
      n_vec++; if (obs_timeout) begin n_err++; $display("FAIL loop_timeout got no done want done"); end
      n_vec++; if (obs_rx !== 8'hA5) begin n_err++; $display("FAIL loop_rx got %h want a5", obs_rx); end
      n_vec++; if (m_low != 18) begin n_err++; $display("FAIL loop_ss_low got %0d want 18", m_low); end
      n_vec++; if (m_rises != 8) begin n_err++; $display("FAIL loop_rises got %0d want 8", m_rises); end
      n_vec++; if (m_done != 1) begin n_err++; $display("FAIL loop_done_width got %0d want 1", m_done); end
      n_vec++; if (obs_busy !== 1'b0) begin n_err++; $display("FAIL loop_busy_at_done got %b want 0", obs_busy); end
      n_vec++; if (m_mosi !== 8'hA5) begin n_err++; $display("FAIL loop_mosi got %h want a5", m_mosi); end
      n_vec++; if (m_tim_err != 0) begin n_err++; $display("FAIL loop_timing got %0d bad edges want 0", m_tim_err); end
      last_exp_rx = 8'hA5;
   endtask

   task automatic test_mode3_slave();
      start_frame(8'h3C, 1'b1, 1'b1, 2'd3, 2, 8'hC3);
      wait_done();
      n_vec++; if (obs_timeout) begin n_err++; $display("FAIL m3_timeout got no done want done"); end
      n_vec++; if (obs_rx !== 8'hC3) begin n_err++; $display("FAIL m3_rx got %h want c3", obs_rx); end
      n_vec++; if (m_low != 72) begin n_err++; $display("FAIL m3_ss_low got %0d want 72", m_low); end
      n_vec++; if (m_mosi !== 8'h3C) begin n_err++; $display("FAIL m3_mosi got %h want 3c", m_mosi); end
      n_vec++; if (m_tim_err != 0 || m_edges != 16) begin n_err++; $display("FAIL m3_edges got %0d edges %0d bad want 16 0", m_edges, m_tim_err); end
      n_vec++; if (m_idle_err != 0 || sck !== 1'b1) begin n_err++; $display("FAIL m3_idle got sck=%b want 1", sck); end
      last_exp_rx = 8'hC3;
   endtask

   task automatic test_back_to_back();
      logic [D-1:0] rx1;
      logic         got1;
      got1 = 1'b0;
      rx1  = '0;
      start_frame(8'h01, 1'b0, 1'b0, 2'd0, 0, 8'h00);
      start   = 1'b1;
      tx_data = 8'h80;
      for (int i = 0; i < 100 && !got1; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin got1 = 1'b1; rx1 = rx_data; end
      end
      @(posedge clk); #1;
      start = 1'b0;
      n_vec++; if (!got1 || rx1 !== 8'h01) begin n_err++; $display("FAIL b2b_rx1 got %h done=%b want 01", rx1, got1); end
      n_vec++; if (ss_n !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL b2b_restart got ss_n=%b busy=%b want 0 1", ss_n, busy); end
      wait_done();
      n_vec++; if (obs_timeout || obs_rx !== 8'h80) begin n_err++; $display("FAIL b2b_rx2 got %h timeout=%b want 80", obs_rx, obs_timeout); end
      n_vec++; if (m_low != 18) begin n_err++; $display("FAIL b2b_ss_low got %0d want 18", m_low); end
      last_exp_rx = 8'h80;
   endtask

   task automatic test_abort();
      logic [D-1:0] tx;
      start_frame(8'h5A, 1'b0, 1'b0, 2'd1, 0, 8'h00);
      repeat (10) @(posedge clk);
      #1;
      n_vec++; if (sck !== 1'b1) begin n_err++; $display("FAIL abort_edge5_sck got %b want 1", sck); end
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      n_vec++;
      if ({ss_n, busy, sck, done} !== {1'b1, 1'b0, 1'b0, 1'b0} || rx_data !== last_exp_rx) begin
         n_err++;
         $display("FAIL abort_state got ss_n=%b busy=%b sck=%b done=%b rx=%h want 1 0 0 0 %h",
                  ss_n, busy, sck, done, rx_data, last_exp_rx);
      end
      repeat (40) @(posedge clk);
      #1;
      n_vec++; if (m_done != 0) begin n_err++; $display("FAIL abort_no_done got %0d pulses want 0", m_done); end
      tx = D'($urandom);
      start_frame(tx, 1'b0, 1'b0, 2'd1, 0, 8'h00);
      wait_done();
      n_vec++; if (obs_timeout || obs_rx !== tx || m_low != 36) begin n_err++; $display("FAIL abort_next_frame got rx=%h low=%0d want %h 36", obs_rx, m_low, tx); end
      last_exp_rx = tx;
   endtask

   task automatic test_reset_mid();
      logic [D-1:0] tx;
      start_frame(8'hE7, 1'b1, 1'b0, 2'd1, 0, 8'h00);
      repeat (14) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      n_vec++;
      if ({sck, mosi, ss_n, busy, done, rx_data} !== {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
         n_err++;
         $display("FAIL rstmid_outputs got sck=%b mosi=%b ss_n=%b busy=%b done=%b rx=%h want 0 0 1 0 0 00",
                  sck, mosi, ss_n, busy, done, rx_data);
      end
      rst = 1'b0;
      last_exp_rx = '0;
      @(posedge clk); #1;
      tx = D'($urandom);
      start_frame(tx, 1'b0, 1'b1, 2'd2, 0, 8'h00);
      repeat (5) @(posedge clk);
      #1;
      tx_data = ~tx; prescaler = 2'd0; cpol = 1'b1; cpha = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done();
      n_vec++; if (obs_timeout || obs_rx !== tx) begin n_err++; $display("FAIL busy_start_rx got %h want %h", obs_rx, tx); end
      n_vec++; if (m_low != 54 || m_tim_err != 0) begin n_err++; $display("FAIL busy_start_timing got low=%0d bad=%0d want 54 0", m_low, m_tim_err); end
      n_vec++; if (ss_n !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL busy_start_queued got ss_n=%b busy=%b want 1 0", ss_n, busy); end
      last_exp_rx = tx;
   endtask

   task automatic test_modes();
      logic [D-1:0] tx;
      logic [D-1:0] exp;
      for (int m = 0; m < 4; m++) begin
         for (int v = 0; v < 2; v++) begin
            tx  = (v == 0) ? 8'hFF : 8'h00;
            exp = model_rx(tx, 1, 8'h00);
            start_frame(tx, m[1], m[0], 2'($urandom_range(0, 3)), 1, 8'h00);
            wait_done();
            n_vec++;
            if (obs_timeout || obs_rx !== exp || m_edges != 16 || m_tim_err != 0) begin
               n_err++;
               $display("FAIL mode%0d_tx%h got rx=%h edges=%0d bad=%0d want %h 16 0",
                        m, tx, obs_rx, m_edges, m_tim_err, exp);
            end
            last_exp_rx = exp;
         end
      end
   endtask

   task automatic test_random();
      logic [D-1:0] tx;
      logic [D-1:0] slv;
      logic [1:0]   ps;
      int           mode;
      for (int i = 0; i < 24; i++) begin
         tx   = D'($urandom);
         slv  = D'($urandom);
         ps   = 2'($urandom_range(0, 3));
         mode = $urandom_range(0, 2);
         start_frame(tx, 1'($urandom), 1'($urandom), ps, mode, slv);
         wait_done();
         n_vec++;
         if (obs_timeout || obs_rx !== model_rx(tx, mode, slv) || m_low != model_low(ps) ||
             m_mosi !== tx || m_done != 1 || m_tim_err != 0 || m_idle_err != 0) begin
            n_err++;
            $display("FAIL rand%0d got rx=%h low=%0d mosi=%h done=%0d bad=%0d want %h %0d %h 1 0",
                     i, obs_rx, m_low, m_mosi, m_done, m_tim_err,
                     model_rx(tx, mode, slv), model_low(ps), tx);
         end
         last_exp_rx = model_rx(tx, mode, slv);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got no finish want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_loopback();
      test_mode3_slave();
      test_back_to_back();
      test_abort();
      test_reset_mid();
      test_modes();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/spi_xfer_ctrl.md
Name: spi_xfer_ctrl

Overview:
Transfer sequencer for the SPI master. It accepts a byte-transfer request from the host-side register block and drives chip select. It generates the divided serial clock with CPOL/CPHA, shifts MOSI out MSB-first and captures MISO. It reports completion with a one-cycle done pulse and the received byte.

Parameters:
DATA_W, 8, bits per transfer (frame length; edges per frame = 2*DATA_W)

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  transfer request; honoured only when busy=0
abort  in  1  synchronous abort of an active transfer
tx_data  in  DATA_W  byte to send, captured on accepted start
prescaler  in  2  SCK divider select: 0=/2, 1=/4, 2=/6, 3=/8; half-period H=prescaler+1 clk cycles
cpol  in  1  SCK idle level
cpha  in  1  0: sample on leading edge; 1: sample on trailing edge
miso  in  1  serial data from slave
sck  out  1  serial clock
mosi  out  1  serial data to slave
ss_n  out  1  active-low slave select
busy  out  1  high from the cycle after start acceptance until done
done  out  1  one-cycle completion pulse
rx_data  out  DATA_W  received byte, valid from done onward

Behaviour:
- Reset: sck=0, mosi=0, ss_n=1, busy=0, done=0, rx_data=0, state IDLE, all counters 0. Reset mid-transfer abandons it with no done pulse.
- All outputs are registered.
- States: IDLE, SETUP, XFER, HOLD, DONE.
- IDLE: sck<=cpol every cycle.
  - start=1 latches tx_data, cpol, cpha and prescaler into shadow registers and moves to SETUP.
  - Port changes after acceptance are ignored until the next accept.
- SETUP (entered cycle T+1 after start sampled at T): ss_n=0, busy=1.
  - If cpha=0, mosi=tx_data[MSB] from this cycle.
  - Stays H cycles, then XFER.
- XFER: sck toggles every H cycles. Edge k (k=1..2*DATA_W) occurs H*k cycles after ss_n falls. Odd k are leading edges, even k are trailing.
  - cpha=0: on leading edges, sample miso into shift register LSB. On trailing edges except the last, drive the next bit onto mosi.
  - cpha=1: on leading edges, drive the next bit onto mosi (first leading edge drives MSB). On trailing edges, sample miso.
  - The sample uses the miso value present in the clk cycle of the edge.
  - After edge 2*DATA_W, sck equals the shadow cpol; go to HOLD.
- HOLD: H cycles with sck idle and ss_n low, then DONE.
- DONE (one cycle): ss_n=1, busy=0, done=1, rx_data=shift register. mosi holds its last value.
  - start in DONE is accepted exactly as in IDLE (back-to-back frames). Otherwise go to IDLE.
- Total ss_n low time = (2*DATA_W+2)*H cycles. For H=1, DATA_W=8: 18 cycles.
- Counters: half-period counter 0..H-1 and edge counter 0..2*DATA_W. The edge counter wraps to 0 on entering SETUP.
- abort=1 in SETUP/XFER/HOLD: next cycle is IDLE with ss_n=1, sck=cpol, busy=0. There is no done pulse and rx_data is unchanged.
- abort in IDLE/DONE has no effect. If abort and start are both asserted in IDLE, start wins.
- start while busy=1 is ignored (no queuing).
- prescaler/cpol/cpha changes during a transfer have no effect.

Test Plan:
1. prescaler=0, cpol=0, cpha=0, tx_data=0xA5, miso looped back to mosi -> 8 rising sck edges, ss_n low 18 cycles, done 1 cycle, rx_data=0xA5, busy low in the done cycle.
2. prescaler=3, cpol=1, cpha=1, tx_data=0x3C, slave model drives 0xC3 -> sck period 8 clk cycles and idles high, mosi stable on rising (trailing) edges, rx_data=0xC3, ss_n low 72 cycles.
3. Back-to-back: start held high through DONE with tx_data 0x01 then 0x80 -> second frame's ss_n falls the cycle after the first done, both rx_data values correct.
4. abort asserted at edge 5 of a prescaler=1 frame -> next cycle ss_n=1, busy=0, sck=cpol, no done, rx_data keeps its previous value; a following start transfers normally.
5. rst asserted mid-XFER -> next cycle all outputs at reset values; start pulse while busy (prescaler=2) ignored, frame completes with the original tx_data.
6. All four cpol/cpha modes with tx_data=0xFF and 0x00, miso=~mosi -> rx_data=0x00/0xFF respectively, edge count exactly 16 per frame.
